multi_channel_watchdog: RTL
===========================

# multi_channel_watchdog

Parametrised N-channel watchdog that supervises independent heartbeat sources. Each channel has a timeout counter, an early-warning threshold, an optional windowed mode that faults on too-early heartbeats, and sticky trip flags. Any trip or a global force request drives a stretched system reset pulse. It sits between the per-subsystem liveness strobes (DSP pipeline, host link, ADC capture) and the board-level reset controller, replacing the single-channel `watchdog_timer`.

## Interface
Parameters:
- `NUM_CH`, 4, number of supervised channels (1..16)
- `CNT_W`, 32, counter width; must hold `TIMEOUT`
- `TIMEOUT`, 50_000_000, cycles without heartbeat before trip (>= 2)
- `WARN_CYCLES`, 37_500_000, counter value at and above which `warning` asserts (< `TIMEOUT`)
- `WINDOW_MIN`, 0, minimum cycles between heartbeats; 0 disables window mode (< `WARN_CYCLES`)
- `RST_HOLD`, 16, length of `sys_reset` pulse in cycles (>= 1)

Ports:
- `clk`, in, 1, single system clock
- `rst`, in, 1, synchronous, active-high reset
- `enable`, in, NUM_CH, per-channel supervise enable
- `heartbeat`, in, NUM_CH, per-channel single-cycle liveness strobe
- `clear`, in, NUM_CH, per-channel sticky-flag clear strobe
- `force_reset`, in, 1, request a `sys_reset` pulse immediately
- `warning`, out, NUM_CH, counter >= `WARN_CYCLES`
- `triggered`, out, NUM_CH, sticky timeout or window fault
- `early_fault`, out, NUM_CH, sticky; trip was caused by a too-early heartbeat
- `any_triggered`, out, 1, OR of `triggered`
- `sys_reset`, out, 1, stretched reset request

## Operation
- Per-channel state: IDLE, ARMING (enabled, no heartbeat yet), RUNNING (at least one heartbeat seen), TRIPPED.
- IDLE: counter = 0, warning = 0. Move to ARMING on the first cycle `enable[i]` = 1.
- ARMING/RUNNING: with no heartbeat, counter += 1 each cycle. A heartbeat sets counter to 0 and moves the channel to RUNNING.
- Window check, RUNNING only, `WINDOW_MIN` > 0: a heartbeat while counter < `WINDOW_MIN` moves the channel to TRIPPED and sets `early_fault[i]`. ARMING never window-faults.
- Timeout: counter == `TIMEOUT`-1 with no heartbeat moves the channel to TRIPPED. The counter freezes.
- Heartbeat in the same cycle as the timeout condition: the heartbeat wins and there is no trip.
- TRIPPED: `triggered[i]` = 1 and `warning[i]` = 0. Heartbeats are ignored. `clear[i]` moves the channel to IDLE, with counter 0, triggered 0 and early_fault 0.
- Trip and `clear[i]` in the same cycle: the trip wins and the flags stay set.
- `enable[i]` low in ARMING/RUNNING: go to IDLE, counter 0. In TRIPPED, enable low does not clear the flags; only `clear[i]` or `rst` does.
- `sys_reset`: a hold counter loads `RST_HOLD` when any channel enters TRIPPED or when `force_reset` = 1. `sys_reset` = (hold counter != 0), and the counter decrements each cycle.
- A new event while the hold counter is nonzero reloads it, so the pulse is retriggerable.
- Counter arithmetic is unsigned `CNT_W`. It never wraps, because it freezes at `TIMEOUT`-1.

## Timing
- Reset values: all channels IDLE, every counter 0. `warning`, `triggered`, `early_fault`, `any_triggered` and `sys_reset` are all 0, and the hold counter is 0.
- `rst` overrides all other inputs in the same edge.
- All outputs are registered. There is no combinational input-to-output path.
- Counter k: value k after the k-th enabled edge. `triggered[i]` is first high `TIMEOUT` cycles after the first enabled cycle with no heartbeat.
- `warning[i]` rises on the edge where the counter becomes `WARN_CYCLES`. It falls on the edge after a heartbeat.
- `sys_reset` rises on the same edge as `triggered` (or the edge after `force_reset` is sampled). It stays high for exactly `RST_HOLD` cycles unless reloaded.
- `any_triggered` is registered alongside `triggered`, with the same latency.

## Test plan
Parameters for all scenarios: `NUM_CH`=2, `TIMEOUT`=8, `WARN_CYCLES`=6, `WINDOW_MIN`=3, `RST_HOLD`=4.

- Reset 2 cycles, then `enable`=01 with no heartbeat. Required: `warning[0]` high from cycle 6, `triggered[0]` and `sys_reset` high from cycle 8, `sys_reset` high for 4 cycles, channel 1 all 0.
- Heartbeat on ch0 every 5 cycles for 100 cycles. Required: `warning`, `triggered` and `sys_reset` stay 0. A heartbeat exactly when the counter = 7 also yields no trip.
- Ch0 in RUNNING, heartbeat at counter = 2. Required: `triggered[0]` = 1, `early_fault[0]` = 1, and `sys_reset` pulses for 4 cycles.
- Ch0 tripped, then `clear[0]` pulse. Required: flags go to 0 and the channel re-arms. `clear[0]` coincident with a trip on the same edge: required that the flags remain 1.
- `force_reset` pulse at t, then again at t+2. Required: `sys_reset` continuous from t+1 to t+6 (reloaded), and all channel flags unchanged.
- `rst` asserted while ch0 is TRIPPED and `sys_reset` is high. Required: all outputs 0 on the next edge and the counters restart from 0.

Source files
------------

// File: rtl/multi_channel_watchdog.sv
// N-channel heartbeat watchdog with early-warning, optional window faults,
// sticky trip flags and a retriggerable stretched system reset request.
module multi_channel_watchdog #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 50_000_000,
   parameter int WARN_CYCLES = 37_500_000,
   parameter int WINDOW_MIN  = 0,
   parameter int RST_HOLD    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] enable,
   input  logic [NUM_CH-1:0] heartbeat,
   input  logic [NUM_CH-1:0] clear,
   input  logic              force_reset,
   output logic [NUM_CH-1:0] warning,
   output logic [NUM_CH-1:0] triggered,
   output logic [NUM_CH-1:0] early_fault,
   output logic              any_triggered,
   output logic              sys_reset
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMING  = 2'd1,
      ST_RUNNING = 2'd2,
      ST_TRIPPED = 2'd3
   } ch_state_t;

   localparam int               HOLD_W    = $clog2(RST_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WARN_TH   = CNT_W'(WARN_CYCLES);
   localparam bit               WIN_EN    = (WINDOW_MIN > 0);
   // Last counter value that still counts as too early; unused when WIN_EN is 0.
   localparam logic [CNT_W-1:0] WIN_LAST  = WIN_EN ? CNT_W'(WINDOW_MIN - 1) : CNT_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   ch_state_t         state_r [NUM_CH];
   ch_state_t         state_s [NUM_CH];
   logic [CNT_W-1:0]  cnt_r   [NUM_CH];
   logic [CNT_W-1:0]  cnt_s   [NUM_CH];
   logic [NUM_CH-1:0] trip_s;
   logic [NUM_CH-1:0] trig_s;
   logic [NUM_CH-1:0] early_s;
   logic [NUM_CH-1:0] warn_s;
   logic [HOLD_W-1:0] hold_r;
   logic [HOLD_W-1:0] hold_s;

   // Per-channel next state, counter and sticky flag computation.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_s[i] = state_r[i];
         cnt_s[i]   = cnt_r[i];
         trig_s[i]  = triggered[i];
         early_s[i] = early_fault[i];
         trip_s[i]  = 1'b0;
         case (state_r[i])
            ST_IDLE: begin
               if (enable[i]) begin
                  state_s[i] = ST_ARMING;
                  cnt_s[i]   = heartbeat[i] ? CNT_W'(0) : CNT_ONE;
               end else begin
                  cnt_s[i] = CNT_W'(0);
               end
            end
            ST_ARMING, ST_RUNNING: begin
               if (!enable[i]) begin
                  state_s[i] = ST_IDLE;
                  cnt_s[i]   = CNT_W'(0);
               end else if (heartbeat[i]) begin
                  // A heartbeat at CNT_LAST lands here first, so it beats the timeout.
                  if (WIN_EN && (state_r[i] == ST_RUNNING) && (cnt_r[i] <= WIN_LAST)) begin
                     state_s[i] = ST_TRIPPED;
                     trip_s[i]  = 1'b1;
                     trig_s[i]  = 1'b1;
                     early_s[i] = 1'b1;
                  end else begin
                     state_s[i] = ST_RUNNING;
                     cnt_s[i]   = CNT_W'(0);
                  end
               end else if (cnt_r[i] == CNT_LAST) begin
                  state_s[i] = ST_TRIPPED;
                  trip_s[i]  = 1'b1;
                  trig_s[i]  = 1'b1;
               end else begin
                  cnt_s[i] = cnt_r[i] + CNT_ONE;
               end
            end
            ST_TRIPPED: begin
               if (clear[i]) begin
                  state_s[i] = ST_IDLE;
                  cnt_s[i]   = CNT_W'(0);
                  trig_s[i]  = 1'b0;
                  early_s[i] = 1'b0;
               end else begin
                  state_s[i] = ST_TRIPPED;
               end
            end
            default: begin
               state_s[i] = ST_IDLE;
               cnt_s[i]   = CNT_W'(0);
               trig_s[i]  = 1'b0;
               early_s[i] = 1'b0;
            end
         endcase
         warn_s[i] = ((state_s[i] == ST_ARMING) || (state_s[i] == ST_RUNNING)) &&
                     (cnt_s[i] >= WARN_TH);
      end
   end

   // Retriggerable hold counter that stretches the system reset request.
   always_comb begin
      hold_s = hold_r;
      if ((|trip_s) || force_reset) begin
         hold_s = HOLD_LOAD;
      end else if (hold_r != HOLD_W'(0)) begin
         hold_s = hold_r - HOLD_ONE;
      end else begin
         hold_s = HOLD_W'(0);
      end
   end

   // State and output registers; rst overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i] <= ST_IDLE;
            cnt_r[i]   <= CNT_W'(0);
         end
         warning       <= '0;
         triggered     <= '0;
         early_fault   <= '0;
         any_triggered <= 1'b0;
         hold_r        <= HOLD_W'(0);
         sys_reset     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i] <= state_s[i];
            cnt_r[i]   <= cnt_s[i];
         end
         warning       <= warn_s;
         triggered     <= trig_s;
         early_fault   <= early_s;
         any_triggered <= |trig_s;
         hold_r        <= hold_s;
         sys_reset     <= (hold_s != HOLD_W'(0));
      end
   end

endmodule
